// File: rtl/imm_ext_pkg.sv
// Shared types for the RISC-V immediate extender: format selects and the stored result entry.
package imm_ext_pkg;

  localparam int XLEN_MAX  = 64;
  localparam int TAG_W_MAX = 16;

  typedef enum logic [2:0] {
    IMM_I     = 3'b000,
    IMM_S     = 3'b001,
    IMM_B     = 3'b010,
    IMM_J     = 3'b011,
    IMM_U     = 3'b100,
    IMM_IU    = 3'b101,
    IMM_SHAMT = 3'b110,
    IMM_ZIMM  = 3'b111
  } imm_src_e;

  // Widest configuration of a stored result; the pipe narrows it to its own XLEN/TAG_W.
  typedef struct packed {
    logic [XLEN_MAX-1:0]  imm;
    logic [TAG_W_MAX-1:0] tag;
    logic                 illegal;
  } imm_entry_t;

endpackage

// File: rtl/imm_ext_core.sv
// Purely combinational immediate decode: instruction word and format select to an XLEN immediate.
module imm_ext_core
  import imm_ext_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:7]     instr,
  input  imm_src_e        imm_src,
  output logic [XLEN-1:0] imm,
  output logic            illegal
);

  // Size casts of $signed operands sign-extend; casts of plain slices zero-extend.
  always_comb begin
    imm     = '0;
    illegal = 1'b0;
    unique case (imm_src)
      IMM_I:  imm = XLEN'($signed(instr[31:20]));
      IMM_S:  imm = XLEN'($signed({instr[31:25], instr[11:7]}));
      IMM_B:  imm = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
      IMM_J:  imm = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
      IMM_U:  imm = XLEN'($signed({instr[31:12], 12'b0}));
      IMM_IU: imm = XLEN'(instr[31:20]);
      IMM_SHAMT: begin
        if (XLEN == 64) begin
          imm = XLEN'(instr[25:20]);
        end else if (instr[25]) begin
          illegal = 1'b1;
        end else begin
          imm = XLEN'(instr[24:20]);
        end
      end
      IMM_ZIMM: imm = XLEN'(instr[19:15]);
      default:  imm = '0;
    endcase
  end

endmodule

// File: rtl/imm_ext_pipe.sv
// Decode-stage immediate extender with valid/ready on both sides and an optional 2-entry skid buffer.
module imm_ext_pipe
  import imm_ext_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5,
  parameter int SKID  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [2:0]       in_imm_src,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_illegal
);

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [TAG_W-1:0] tag;
    logic             illegal;
  } entry_t;

  entry_t          new_entry;
  entry_t          head;
  logic [XLEN-1:0] dec_imm;
  logic            dec_illegal;
  logic            push;
  logic            pop;
  logic            unused_opcode;

  assign unused_opcode = ^in_instr[6:0];

  imm_ext_core #(.XLEN(XLEN)) u_core (
    .instr   (in_instr[31:7]),
    .imm_src (imm_src_e'(in_imm_src)),
    .imm     (dec_imm),
    .illegal (dec_illegal)
  );

  // The immediate is resolved at enqueue so storage only ever holds finished results.
  assign new_entry = '{imm: dec_imm, tag: in_tag, illegal: dec_illegal};
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  generate
    if (SKID != 0) begin : g_skid
      entry_t [1:0] mem;
      logic         rd_ptr;
      logic         wr_ptr;
      logic [1:0]   count;

      // in_ready depends only on the registered count, isolating the producer from out_ready.
      assign in_ready  = !rst && (count != 2'd2);
      assign out_valid = (count != 2'd0);
      assign head      = mem[rd_ptr];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          mem    <= '0;
          rd_ptr <= 1'b0;
          wr_ptr <= 1'b0;
          count  <= 2'd0;
        end else begin
          if (push) begin
            mem[wr_ptr] <= new_entry;
            wr_ptr      <= ~wr_ptr;
          end
          if (pop) begin
            rd_ptr <= ~rd_ptr;
          end
          count <= count + {1'b0, push} - {1'b0, pop};
        end
      end
    end else begin : g_single
      entry_t q;
      logic   v;

      // A pop frees the register in the same edge, so out_ready feeds in_ready directly.
      assign in_ready  = !rst && (!v || out_ready);
      assign out_valid = v;
      assign head      = q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          q <= '0;
          v <= 1'b0;
        end else if (push) begin
          q <= new_entry;
          v <= 1'b1;
        end else if (pop) begin
          v <= 1'b0;
        end
      end
    end
  endgenerate

  assign out_imm     = head.imm;
  assign out_tag     = head.tag;
  assign out_illegal = head.illegal;

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Bench for imm_ext_pipe: three configurations driven in lockstep against queue-based reference models.
module tb_imm_ext_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] in_instr = '0;
  logic [2:0]  in_imm_src = '0;
  logic [4:0]  in_tag = '0;

  logic [2:0]      ir;
  logic [2:0]      ov;
  logic [2:0]      ill;
  logic [31:0]     imm_a;
  logic [63:0]     imm_b;
  logic [31:0]     imm_c;
  logic [2:0][4:0] tag_w;

  always #5 clk = ~clk;

  imm_ext_pipe #(.XLEN(32), .TAG_W(5), .SKID(1)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[0]), .in_instr(in_instr),
    .in_imm_src(in_imm_src), .in_tag(in_tag), .out_valid(ov[0]), .out_ready(out_ready),
    .out_imm(imm_a), .out_tag(tag_w[0]), .out_illegal(ill[0]));

  imm_ext_pipe #(.XLEN(64), .TAG_W(5), .SKID(1)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[1]), .in_instr(in_instr),
    .in_imm_src(in_imm_src), .in_tag(in_tag), .out_valid(ov[1]), .out_ready(out_ready),
    .out_imm(imm_b), .out_tag(tag_w[1]), .out_illegal(ill[1]));

  imm_ext_pipe #(.XLEN(32), .TAG_W(5), .SKID(0)) dut_c (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[2]), .in_instr(in_instr),
    .in_imm_src(in_imm_src), .in_tag(in_tag), .out_valid(ov[2]), .out_ready(out_ready),
    .out_imm(imm_c), .out_tag(tag_w[2]), .out_illegal(ill[2]));

  typedef struct {
    logic [63:0] imm;
    logic [4:0]  tag;
    bit          ill;
  } ent_t;

  typedef struct {
    logic [31:0] instr;
    logic [2:0]  src;
    logic [4:0]  tag;
    logic [63:0] exp32;
    bit          ill32;
    logic [63:0] exp64;
    bit          ill64;
  } vec_t;

  ent_t       mq[3][$];
  int         n_cmp = 0;
  int         n_fail = 0;
  int         pop_cnt[3];
  logic [4:0] pop_log[$];
  vec_t       vecs[11];

  function automatic bit is64(int i);
    return i == 1;
  endfunction

  function automatic bit isskid(int i);
    return i != 2;
  endfunction

  function automatic logic [63:0] dut_imm(int i);
    case (i)
      0:       return {32'b0, imm_a};
      1:       return imm_b;
      default: return {32'b0, imm_c};
    endcase
  endfunction

  // Immediate value as a signed number: sign weight of the top bit plus the unsigned field.
  function automatic logic [63:0] ref_imm(bit x64, logic [31:0] ins, logic [2:0] src, output bit il);
    longint sgn;
    longint v;
    il  = 1'b0;
    sgn = ins[31] ? -64'sd1 : 64'sd0;
    case (src)
      3'd0: v = sgn * 4096 + longint'(ins[31:20]);
      3'd1: v = sgn * 4096 + longint'(ins[31:25]) * 32 + longint'(ins[11:7]);
      3'd2: v = sgn * 8192 + longint'(ins[31]) * 4096 + longint'(ins[7]) * 2048
              + longint'(ins[30:25]) * 32 + longint'(ins[11:8]) * 2;
      3'd3: v = sgn * 2097152 + longint'(ins[31]) * 1048576 + longint'(ins[19:12]) * 4096
              + longint'(ins[20]) * 2048 + longint'(ins[30:21]) * 2;
      3'd4: v = sgn * 64'sh1_0000_0000 + longint'(ins[31:12]) * 4096;
      3'd5: v = longint'(ins[31:20]);
      3'd6: begin
        if (x64) v = longint'(ins[25:20]);
        else if (ins[25]) begin v = 0; il = 1'b1; end
        else v = longint'(ins[24:20]);
      end
      default: v = longint'(ins[19:15]);
    endcase
    if (!x64) v = v & 64'sh0000_0000_FFFF_FFFF;
    return v;
  endfunction

  function automatic bit model_ready(int i);
    if (rst) return 1'b0;
    if (isskid(i)) return mq[i].size() < 2;
    return (mq[i].size() == 0) || out_ready;
  endfunction

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic checkOutput(input string ctx);
    for (int i = 0; i < 3; i++) begin
      cmp($sformatf("%s/dut%0d/in_ready", ctx, i), 64'(ir[i]), 64'(model_ready(i)));
      cmp($sformatf("%s/dut%0d/out_valid", ctx, i), 64'(ov[i]), 64'(mq[i].size() != 0));
      if (mq[i].size() != 0) begin
        cmp($sformatf("%s/dut%0d/out_imm", ctx, i), dut_imm(i), mq[i][0].imm);
        cmp($sformatf("%s/dut%0d/out_tag", ctx, i), 64'(tag_w[i]), 64'(mq[i][0].tag));
        cmp($sformatf("%s/dut%0d/out_illegal", ctx, i), 64'(ill[i]), 64'(mq[i][0].ill));
      end
      if (ov[i] && out_ready) begin
        pop_cnt[i]++;
        if (i == 0) pop_log.push_back(tag_w[0]);
      end
    end
  endtask

  // One clock: drive, check the DUTs against the models, then advance the models past the edge.
  task automatic applyStimulus(input bit v, input logic [31:0] ins, input logic [2:0] src,
                               input logic [4:0] tag, input bit ordy, input string ctx);
    bit   do_push[3];
    bit   do_pop[3];
    ent_t e;
    bit   il;
    @(negedge clk);
    in_valid   = v;
    in_instr   = ins;
    in_imm_src = src;
    in_tag     = tag;
    out_ready  = ordy;
    #1;
    checkOutput(ctx);
    for (int i = 0; i < 3; i++) begin
      do_push[i] = v && model_ready(i);
      do_pop[i]  = (mq[i].size() != 0) && ordy;
    end
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      if (do_pop[i]) mq[i].delete(0);
      if (do_push[i]) begin
        e.imm = ref_imm(is64(i), ins, src, il);
        e.tag = tag;
        e.ill = il;
        mq[i].push_back(e);
      end
    end
  endtask

  initial begin
    vecs[0]  = '{32'hFFF00093, 3'd0, 5'd1,  64'hFFFFFFFF, 1'b0, 64'hFFFFFFFFFFFFFFFF, 1'b0};
    vecs[1]  = '{32'hFE000EE3, 3'd2, 5'd2,  64'hFFFFFFFC, 1'b0, 64'hFFFFFFFFFFFFFFFC, 1'b0};
    vecs[2]  = '{32'h800000B7, 3'd4, 5'd3,  64'h80000000, 1'b0, 64'hFFFFFFFF80000000, 1'b0};
    vecs[3]  = '{32'h02300013, 3'd6, 5'd4,  64'h0,        1'b1, 64'h23,               1'b0};
    vecs[4]  = '{32'h000A8073, 3'd7, 5'd5,  64'h15,       1'b0, 64'h15,               1'b0};
    vecs[5]  = '{32'hFFF00093, 3'd5, 5'd6,  64'hFFF,      1'b0, 64'hFFF,              1'b0};
    vecs[6]  = '{32'hFE000F80, 3'd1, 5'd7,  64'hFFFFFFFF, 1'b0, 64'hFFFFFFFFFFFFFFFF, 1'b0};
    vecs[7]  = '{32'h800000EF, 3'd3, 5'd8,  64'hFFF00000, 1'b0, 64'hFFFFFFFFFFF00000, 1'b0};
    vecs[8]  = '{32'h0010006F, 3'd3, 5'd9,  64'h800,      1'b0, 64'h800,              1'b0};
    vecs[9]  = '{32'h00500013, 3'd6, 5'd10, 64'h5,        1'b0, 64'h5,                1'b0};
    vecs[10] = '{32'h7FF00013, 3'd0, 5'd11, 64'h7FF,      1'b0, 64'h7FF,              1'b0};

    // Reset state while rst is held high.
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      cmp($sformatf("reset/dut%0d/in_ready", i), 64'(ir[i]), 64'd0);
      cmp($sformatf("reset/dut%0d/out_valid", i), 64'(ov[i]), 64'd0);
      cmp($sformatf("reset/dut%0d/out_imm", i), dut_imm(i), 64'd0);
      cmp($sformatf("reset/dut%0d/out_tag", i), 64'(tag_w[i]), 64'd0);
      cmp($sformatf("reset/dut%0d/out_illegal", i), 64'(ill[i]), 64'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    for (int i = 0; i < 3; i++)
      cmp($sformatf("post_reset/dut%0d/in_ready", i), 64'(ir[i]), 64'd1);

    // Table vectors streamed back to back; each result is checked one cycle after acceptance.
    for (int k = 0; k < 11; k++) begin
      applyStimulus(1'b1, vecs[k].instr, vecs[k].src, vecs[k].tag, 1'b1, $sformatf("vec%0d", k));
      #2;
      for (int i = 0; i < 3; i++) begin
        cmp($sformatf("vec%0d/dut%0d/out_valid", k, i), 64'(ov[i]), 64'd1);
        cmp($sformatf("vec%0d/dut%0d/out_imm", k, i), dut_imm(i), is64(i) ? vecs[k].exp64 : vecs[k].exp32);
        cmp($sformatf("vec%0d/dut%0d/out_illegal", k, i), 64'(ill[i]),
            64'(is64(i) ? vecs[k].ill64 : vecs[k].ill32));
        cmp($sformatf("vec%0d/dut%0d/out_tag", k, i), 64'(tag_w[i]), 64'(vecs[k].tag));
      end
    end
    repeat (2) applyStimulus(1'b0, '0, '0, '0, 1'b1, "drain_a");

    // Streaming: 16 back-to-back requests must yield 16 results.
    for (int i = 0; i < 3; i++) pop_cnt[i] = 0;
    for (int k = 0; k < 16; k++)
      applyStimulus(1'b1, $urandom, 3'($urandom_range(0, 7)), 5'(k), 1'b1, $sformatf("stream%0d", k));
    repeat (2) applyStimulus(1'b0, '0, '0, '0, 1'b1, "stream_drain");
    for (int i = 0; i < 3; i++)
      cmp($sformatf("stream/dut%0d/result_count", i), 64'(pop_cnt[i]), 64'd16);

    // Backpressure on the skid buffer: tags 1,2,3 offered while stalled.
    pop_log.delete();
    applyStimulus(1'b1, 32'h12345013, 3'd0, 5'd1, 1'b0, "bp_push1");
    applyStimulus(1'b1, 32'hABCDE013, 3'd4, 5'd2, 1'b0, "bp_push2");
    applyStimulus(1'b1, 32'hFE000EE3, 3'd2, 5'd3, 1'b0, "bp_offer3");
    #1;
    cmp("bp/dut0/in_ready_full", 64'(ir[0]), 64'd0);
    applyStimulus(1'b1, 32'hFE000EE3, 3'd2, 5'd3, 1'b0, "bp_stall");
    applyStimulus(1'b1, 32'hFE000EE3, 3'd2, 5'd3, 1'b1, "bp_pop1");
    applyStimulus(1'b1, 32'hFE000EE3, 3'd2, 5'd3, 1'b1, "bp_pop2");
    applyStimulus(1'b0, '0, '0, '0, 1'b1, "bp_pop3");
    applyStimulus(1'b0, '0, '0, '0, 1'b1, "bp_idle");
    cmp("bp/dut0/pop_count", 64'(pop_log.size()), 64'd3);
    for (int k = 0; k < 3; k++)
      if (pop_log.size() > k)
        cmp($sformatf("bp/dut0/order%0d", k), 64'(pop_log[k]), 64'(k + 1));

    // Reset with entries held must clear outputs without a clock edge.
    applyStimulus(1'b1, 32'hFFF00093, 3'd0, 5'd11, 1'b0, "rst_fill1");
    applyStimulus(1'b1, 32'h800000B7, 3'd4, 5'd12, 1'b0, "rst_fill2");
    #1;
    rst      = 1'b1;
    in_valid = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      cmp($sformatf("midrst/dut%0d/out_valid", i), 64'(ov[i]), 64'd0);
      cmp($sformatf("midrst/dut%0d/out_imm", i), dut_imm(i), 64'd0);
      cmp($sformatf("midrst/dut%0d/out_tag", i), 64'(tag_w[i]), 64'd0);
      cmp($sformatf("midrst/dut%0d/in_ready", i), 64'(ir[i]), 64'd0);
      mq[i].delete();
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      cmp($sformatf("after_rst/dut%0d/in_ready", i), 64'(ir[i]), 64'd1);
      cmp($sformatf("after_rst/dut%0d/out_valid", i), 64'(ov[i]), 64'd0);
    end
    applyStimulus(1'b0, '0, '0, '0, 1'b1, "after_rst_idle");

    // Randomised traffic with random backpressure.
    for (int k = 0; k < 300; k++)
      applyStimulus($urandom_range(0, 9) < 7, $urandom, 3'($urandom_range(0, 7)), 5'($urandom),
                    $urandom_range(0, 9) < 7, $sformatf("rand%0d", k));
    repeat (3) applyStimulus(1'b0, '0, '0, '0, 1'b1, "final_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/imm_ext_pipe.md
# imm_ext_pipe

Pipelined, parametrised immediate extender for the RISC-V decode stage. It accepts an instruction word with an immediate-format select under a valid/ready handshake and produces the sign- or zero-extended immediate at XLEN width. It also passes through a sideband tag (typically rd/ROB id) and flags malformed shift amounts. It sits between the fetch/decode register and the ID/EX pipeline register, and decouples their backpressure with an optional 2-entry skid buffer.

## Interface
- XLEN, 32, datapath width; legal values 32 or 64.
- TAG_W, 5, width of the pass-through sideband tag.
- SKID, 1, 1 = 2-entry skid buffer (registered in_ready); 0 = single output register (in_ready combinational from out_ready).
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  request valid.
- in_ready  output  1  block can accept this cycle.
- in_instr  input  32  instruction word; bits [6:0] ignored.
- in_imm_src  input  3  immediate format, per imm_ext_pkg.
- in_tag  input  TAG_W  sideband, returned unchanged.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts.
- out_imm  output  XLEN  extended immediate.
- out_tag  output  TAG_W  tag of this result.
- out_illegal  output  1  immediate field malformed for this XLEN.

## Operation
- Formats; sext = sign-extend from instr[31] to XLEN:
  - 000 I: sext(instr[31:20]).
  - 001 S: sext({instr[31:25],instr[11:7]}).
  - 010 B: sext({instr[31],instr[7],instr[30:25],instr[11:8],0}).
  - 011 J: sext({instr[31],instr[19:12],instr[20],instr[30:21],0}).
  - 100 U: sext({instr[31:12],12'b0}); at XLEN=64 upper 32 bits copy instr[31].
  - 101 IU: zero-extend instr[31:20] (sltiu/unsigned compare).
  - 110 SHAMT: XLEN=64: zext(instr[25:20]). XLEN=32: zext(instr[24:20]); if instr[25]=1, out_illegal=1 and out_imm=0.
  - 111 ZIMM: zext(instr[19:15]) (CSR immediate).
- out_illegal is 0 for every case other than the XLEN=32 SHAMT case above.
- Extension is computed at enqueue. The stored {imm, tag, illegal} is what is presented at the output.
- Transfer occurs on valid&&ready at each port. Results leave in acceptance order.
- SKID=1: occupancy count 0..2. in_ready = (count!=2). out_valid = (count!=0). Simultaneous push and pop at count 1 keeps count 1 and presents the new entry next cycle.
- SKID=0: in_ready = !out_valid || out_ready. A push replaces the register in the same edge that pops it.
- While out_valid && !out_ready, out_imm, out_tag and out_illegal hold stable.
- Reset (async, any time, including mid-operation) discards all entries.
  - count=0, out_valid=0, out_imm=0, out_tag=0, out_illegal=0.
  - in_ready=0 while rst is high, and 1 from the first cycle after deassertion.

## Timing
- Latency: 1 cycle. A request accepted at edge N gives out_valid high after edge N, so the result can be popped at edge N+1.
- Throughput: 1 result per cycle with out_ready held high, in both SKID modes.
- SKID=1 has no combinational path from out_ready to in_ready. SKID=0 has that one path.
- A full buffer needs 2 pops before it can accept 2 further pushes. in_ready rises in the cycle after the first pop.

## Structure
- imm_ext_pkg: IMM_I, IMM_S, IMM_B, IMM_J, IMM_U, IMM_IU, IMM_SHAMT, IMM_ZIMM constants as a 3-bit enum type; the entry struct {imm, tag, illegal}.
- Sub-module imm_ext_core: purely combinational decode (instr, imm_src) -> (imm, illegal), parametrised by XLEN.
- imm_ext_pipe holds the handshake, the storage (2-entry circular buffer or single register, selected by SKID generate) and the reset logic.

## Test plan
- I, XLEN=32: instr 32'hFFF00093, src 000, tag 5'd1 -> next cycle out_imm 32'hFFFFFFFF, out_tag 1, out_illegal 0.
- B/U, XLEN=64:
  - 32'hFE000EE3, src 010 -> 64'hFFFFFFFFFFFFFFFC.
  - 32'h800000B7, src 100 -> 64'hFFFFFFFF80000000.
- SHAMT and ZIMM, XLEN=32:
  - instr[25:20]=6'b100011, src 110 -> out_illegal 1, out_imm 0.
  - Same instr at XLEN=64 -> out_imm 35, out_illegal 0.
  - instr[19:15]=5'b10101, src 111 -> 32'h15.
- Backpressure, SKID=1: hold out_ready=0 and offer 3 requests with tags 1,2,3 -> 2 accepted, in_ready=0. Then release out_ready -> tags 1,2,3 emerge in order, no loss or duplication. out_imm stays stable while stalled.
- Streaming, both SKID values: 16 back-to-back requests with out_ready=1 -> 16 results on consecutive cycles, 1-cycle latency.
- Reset mid-operation: assert rst with 2 entries held -> out_valid=0 and out_imm=0 immediately, without waiting for a clock edge. After deassertion, in_ready=1 and no stale entry appears.
